// File: rtl/risc_pkg.sv
// Shared widths, ALU function codes, ID/EX payload and operand forwarding helper.
package risc_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned ALU_W    = 3;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_INV = 3'b010;
    localparam logic [ALU_W-1:0] ALU_LSL = 3'b011;
    localparam logic [ALU_W-1:0] ALU_LSR = 3'b100;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b101;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    // ID/EX pipeline register payload
    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ALU_W-1:0]  alu_control;
        logic [ADDR_W-1:0] rd;
    } idex_t;

    // Resolve one source operand: r0, then EX forward, then WB bypass, then register file
    function automatic logic [DATA_W-1:0] fwd_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_fwd_en,
        input logic [ADDR_W-1:0] ex_rd,
        input logic [DATA_W-1:0] ex_result,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0] wb_data
    );
        logic [DATA_W-1:0] val;
        val = rf_val;
        if (src == '0) begin
            val = '0;
        end else if (ex_fwd_en && (ex_rd == src)) begin
            val = ex_result;
        end else if (wb_en && (wb_addr == src)) begin
            val = wb_data;
        end
        return val;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: NUM_REGS x DATA_W, two combinational reads, one write.
// r0 always reads zero and is never written; synchronous active-high reset clears all.
// Ports:
//   clk, reset            clock and synchronous reset
//   raddr_a/b, rdata_a/b_c   read ports (combinational data)
//   wen, waddr, wdata     write port, applied on the rising edge
module reg_file
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a_c,
    output logic [DATA_W-1:0] rdata_b_c,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    // Write port; reset drops any concurrent write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wen && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // Read ports with r0 hardwired to zero
    always_comb begin
        rdata_a_c = '0;
        rdata_b_c = '0;
        if (raddr_a != '0) rdata_a_c = regs[raddr_a];
        if (raddr_b != '0) rdata_b_c = regs[raddr_b];
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: register file, EX/WB operand forwarding and the ID/EX
// pipeline register feeding the ALU. Supports stall (hold) and flush (bubble).
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   id_*                               decoded instruction fields
//   stall, flush                       ID/EX hold / bubble controls (flush wins)
//   ex_result                          combinational ALU result of the ID/EX instruction
//   wb_en, wb_addr, wb_data            writeback port
//   ex_valid, ex_a, ex_b, ex_alu_control, ex_rd, ex_reg_write   registered ID/EX outputs
module operand_fetch_stage
    import risc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs1,
    input  logic [ADDR_W-1:0] id_rs2,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_use_imm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [ALU_W-1:0]  id_alu_control,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [ALU_W-1:0]  ex_alu_control,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_reg_write
);

    idex_t             idex_q;
    idex_t             idex_next_c;
    logic [DATA_W-1:0] rf_a_c;
    logic [DATA_W-1:0] rf_b_c;
    logic [DATA_W-1:0] op_a_c;
    logic [DATA_W-1:0] op_b_c;
    logic              ex_fwd_en_c;

    reg_file u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .raddr_a   (id_rs1),
        .raddr_b   (id_rs2),
        .rdata_a_c (rf_a_c),
        .rdata_b_c (rf_b_c),
        .wen       (wb_en),
        .waddr     (wb_addr),
        .wdata     (wb_data)
    );

    // Operand resolution; ex_result is only meaningful while its producer sits in ID/EX
    always_comb begin
        ex_fwd_en_c = idex_q.valid && idex_q.reg_write;
        op_a_c = fwd_operand(id_rs1, rf_a_c, ex_fwd_en_c, idex_q.rd, ex_result,
                             wb_en, wb_addr, wb_data);
        op_b_c = id_imm;
        if (!id_use_imm) begin
            op_b_c = fwd_operand(id_rs2, rf_b_c, ex_fwd_en_c, idex_q.rd, ex_result,
                                 wb_en, wb_addr, wb_data);
        end
    end

    // ID/EX next value: flush > stall > advance
    always_comb begin
        idex_next_c             = idex_q;
        if (flush) begin
            idex_next_c         = '0;
        end else if (!stall) begin
            idex_next_c.valid       = id_valid;
            idex_next_c.reg_write   = id_valid && id_reg_write;
            idex_next_c.a           = op_a_c;
            idex_next_c.b           = op_b_c;
            idex_next_c.alu_control = id_alu_control;
            idex_next_c.rd          = id_rd;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_next_c;
        end
    end

    assign ex_valid       = idex_q.valid;
    assign ex_reg_write   = idex_q.reg_write;
    assign ex_a           = idex_q.a;
    assign ex_b           = idex_q.b;
    assign ex_alu_control = idex_q.alu_control;
    assign ex_rd          = idex_q.rd;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, register reads, forwarding priority,
// r0 behaviour, stall/flush and immediate selection.
module tb_operand_fetch_stage;
    import risc_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs1;
    logic [ADDR_W-1:0] id_rs2;
    logic [ADDR_W-1:0] id_rd;
    logic              id_reg_write;
    logic              id_use_imm;
    logic [DATA_W-1:0] id_imm;
    logic [ALU_W-1:0]  id_alu_control;
    logic              stall;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_valid;
    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [ALU_W-1:0]  ex_alu_control;
    logic [ADDR_W-1:0] ex_rd;
    logic              ex_reg_write;

    int tests_run = 0;
    int tests_failed = 0;

    operand_fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_use_imm     (id_use_imm),
        .id_imm         (id_imm),
        .id_alu_control (id_alu_control),
        .stall          (stall),
        .flush          (flush),
        .ex_result      (ex_result),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .ex_valid       (ex_valid),
        .ex_a           (ex_a),
        .ex_b           (ex_b),
        .ex_alu_control (ex_alu_control),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [ADDR_W-1:0] rs1, input logic [ADDR_W-1:0] rs2,
                          input logic [ADDR_W-1:0] rd, input logic rw, input logic [ALU_W-1:0] alu);
        id_valid       = v;
        id_rs1         = rs1;
        id_rs2         = rs2;
        id_rd          = rd;
        id_reg_write   = rw;
        id_alu_control = alu;
    endtask

    logic [DATA_W-1:0] hold_a, hold_b;

    initial begin
        reset = 1'b1;
        set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, ALU_OR);
        id_use_imm = 1'b0;
        id_imm     = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        ex_result  = 16'hDEAD;
        wb_en      = 1'b1;
        wb_addr    = 3'd4;
        wb_data    = 16'h9999;

        // 1. Reset for two cycles, then read back r1..r7
        step();
        step();
        check("rst_valid", 32'(ex_valid), 32'd0);
        check("rst_rw",    32'(ex_reg_write), 32'd0);
        check("rst_a",     32'(ex_a), 32'd0);
        check("rst_b",     32'(ex_b), 32'd0);
        check("rst_alu",   32'(ex_alu_control), 32'd0);
        check("rst_rd",    32'(ex_rd), 32'd0);
        reset = 1'b0;
        wb_en = 1'b0;
        for (int k = 1; k < 8; k++) begin
            set_id(1'b1, 3'(k), 3'(k), 3'd1, 1'b0, ALU_ADD);
            step();
            check($sformatf("rst_rf_a%0d", k), 32'(ex_a), 32'd0);
            check($sformatf("rst_rf_b%0d", k), 32'(ex_b), 32'd0);
        end

        // 2. Write r3, then read it on both ports
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, ALU_ADD);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234;
        step();
        wb_en = 1'b0;
        set_id(1'b1, 3'd3, 3'd3, 3'd1, 1'b0, ALU_ADD);
        step();
        check("rf_r3_a",   32'(ex_a), 32'h1234);
        check("rf_r3_b",   32'(ex_b), 32'h1234);
        check("rf_r3_alu", 32'(ex_alu_control), 32'(ALU_ADD));
        check("rf_r3_vld", 32'(ex_valid), 32'd1);

        // Same-cycle WB bypass
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h5555;
        set_id(1'b1, 3'd4, 3'd3, 3'd1, 1'b0, ALU_SUB);
        step();
        check("wb_bypass_a", 32'(ex_a), 32'h5555);
        check("wb_bypass_b", 32'(ex_b), 32'h1234);

        // 3. EX forward beats WB bypass
        wb_en = 1'b0;
        set_id(1'b1, 3'd0, 3'd0, 3'd2, 1'b1, ALU_ADD);
        step();
        check("prod_rw", 32'(ex_reg_write), 32'd1);
        check("prod_rd", 32'(ex_rd), 32'd2);
        ex_result = 16'h00FF;
        wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h0001;
        set_id(1'b1, 3'd2, 3'd0, 3'd2, 1'b1, ALU_ADD);
        step();
        check("ex_fwd_over_wb", 32'(ex_a), 32'h00FF);
        wb_en = 1'b0;
        ex_result = 16'hBEEF;
        set_id(1'b1, 3'd2, 3'd2, 3'd6, 1'b0, ALU_ADD);
        step();
        check("ex_fwd_a", 32'(ex_a), 32'hBEEF);
        check("ex_fwd_b", 32'(ex_b), 32'hBEEF);
        step();
        check("rf_r2_after_wb", 32'(ex_a), 32'h0001);
        check("no_rw_id_rw",    32'(ex_reg_write), 32'd0);

        // Invalid instruction never asserts reg_write
        set_id(1'b0, 3'd2, 3'd2, 3'd2, 1'b1, ALU_ADD);
        step();
        check("inv_valid", 32'(ex_valid), 32'd0);
        check("inv_rw",    32'(ex_reg_write), 32'd0);

        // 4. Writes to r0 are ignored; r0 reads zero even with a matching EX producer
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF;
        set_id(1'b1, 3'd0, 3'd0, 3'd0, 1'b1, ALU_ADD);
        step();
        wb_en = 1'b0;
        ex_result = 16'hAAAA;
        set_id(1'b1, 3'd0, 3'd0, 3'd1, 1'b0, ALU_ADD);
        step();
        check("r0_a", 32'(ex_a), 32'd0);
        check("r0_b", 32'(ex_b), 32'd0);

        // 5. Stall holds all ID/EX fields for three cycles
        set_id(1'b1, 3'd3, 3'd2, 3'd5, 1'b1, ALU_SUB);
        step();
        check("pre_stall_a", 32'(ex_a), 32'h1234);
        check("pre_stall_b", 32'(ex_b), 32'h0001);
        hold_a = 16'h1234;
        hold_b = 16'h0001;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_id(k[0], 3'(k + 1), 3'(k + 4), 3'(k), 1'b0, 3'(k + 4));
            ex_result = 16'(k * 16'h1111);
            step();
            check($sformatf("stall_a%0d", k),   32'(ex_a), 32'(hold_a));
            check($sformatf("stall_b%0d", k),   32'(ex_b), 32'(hold_b));
            check($sformatf("stall_alu%0d", k), 32'(ex_alu_control), 32'(ALU_SUB));
            check($sformatf("stall_rd%0d", k),  32'(ex_rd), 32'd5);
            check($sformatf("stall_vld%0d", k), 32'(ex_valid), 32'd1);
            check($sformatf("stall_rw%0d", k),  32'(ex_reg_write), 32'd1);
        end
        flush = 1'b1;
        step();
        check("flush_vld", 32'(ex_valid), 32'd0);
        check("flush_rw",  32'(ex_reg_write), 32'd0);
        check("flush_a",   32'(ex_a), 32'd0);
        check("flush_rd",  32'(ex_rd), 32'd0);
        stall = 1'b0;
        flush = 1'b0;

        // 6. Immediate selection for operand b
        wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h7777;
        set_id(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, ALU_ADD);
        step();
        wb_en = 1'b0;
        id_use_imm = 1'b1;
        id_imm = 16'h0004;
        set_id(1'b1, 3'd5, 3'd5, 3'd7, 1'b1, ALU_AND);
        step();
        check("imm_b",   32'(ex_b), 32'h0004);
        check("imm_a",   32'(ex_a), 32'h7777);
        check("imm_alu", 32'(ex_alu_control), 32'(ALU_AND));

        // Reset mid-stream clears ID/EX and drops the concurrent write
        reset = 1'b1;
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'hAAAA;
        step();
        check("midrst_vld", 32'(ex_valid), 32'd0);
        check("midrst_b",   32'(ex_b), 32'd0);
        reset = 1'b0;
        wb_en = 1'b0;
        id_use_imm = 1'b0;
        set_id(1'b1, 3'd6, 3'd5, 3'd1, 1'b0, ALU_ADD);
        step();
        check("midrst_r6", 32'(ex_a), 32'd0);
        check("midrst_r5", 32'(ex_b), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
